// File: rtl/vga_sync_gen.sv
// vga_sync_gen - VGA raster timing generator.
//
// Purpose: walks a pixel position (DrawX, DrawY) across a frame of
// H_TOTAL x V_TOTAL positions. It derives active-low horizontal and vertical
// syncs and a display-enable flag from that position. All outputs come from
// registers loaded from the *next* counter values, so in any cycle every
// output describes the same (DrawX, DrawY) pair.
//
// Ports:
//   vga_clk     in   1   pixel clock, all logic on the rising edge
//   Reset       in   1   synchronous active-high reset
//   DrawX       out  10  horizontal position, 0..H_TOTAL-1
//   DrawY       out  10  vertical position, 0..V_TOTAL-1
//   hs          out  1   horizontal sync, active low
//   vs          out  1   vertical sync, active low
//   blank       out  1   1 = visible region (display enable), 0 = blanking
//   sync        out  1   composite sync, constant 0
//   frame_start out  1   one-cycle pulse on the (0,0) that follows
//                        (H_TOTAL-1, V_TOTAL-1)
//   frame_count out  16  frames started since reset, wraps at 0xFFFF
//                        (present only with VGA_SYNC_FRAME_CNT_EN defined)
//
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN adds the frame_count port
// and its register. Without the macro neither exists.
//
// Counter arithmetic is 10 bits wide, so H_TOTAL and V_TOTAL must not
// exceed 1024.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        vga_clk,
  input  logic        Reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        sync,
  output logic        frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END   = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG  = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END  = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_VIS_END   = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_BEG  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END  = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank;
  logic       r_frame_start;

  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_frame_wrap;
  logic       w_hs_next;
  logic       w_vs_next;
  logic       w_blank_next;

  // Next raster position. The line wrap and the frame wrap happen in the
  // same cycle as the DrawX wrap, which gives (0,0) on a full frame wrap.
  always_comb begin
    w_x_next     = r_x + 10'd1;
    w_y_next     = r_y;
    w_frame_wrap = 1'b0;
    if (r_x == H_LAST) begin
      w_x_next = 10'd0;
      if (r_y == V_LAST) begin
        w_y_next     = 10'd0;
        w_frame_wrap = 1'b1;
      end else begin
        w_y_next = r_y + 10'd1;
      end
    end
  end

  // Sync and enable decode the next position, so the registered copies line
  // up with the registered counters.
  always_comb begin
    w_hs_next    = !((w_x_next >= H_SYNC_BEG) && (w_x_next < H_SYNC_END));
    w_vs_next    = !((w_y_next >= V_SYNC_BEG) && (w_y_next < V_SYNC_END));
    w_blank_next = (w_x_next < H_VIS_END) && (w_y_next < V_VIS_END);
  end

  // The reset values match the decode of position (0,0), which is what the
  // outputs show while Reset is held.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_hs          <= w_hs_next;
      r_vs          <= w_vs_next;
      r_blank       <= w_blank_next;
      r_frame_start <= w_frame_wrap;
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] r_frame_count;

  // Steps in the same cycle that frame_start rises. Natural 16-bit overflow
  // provides the 0xFFFF -> 0x0000 wrap.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_frame_count <= 16'd0;
    end else if (w_frame_wrap) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`endif

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign blank       = r_blank;
  assign sync        = 1'b0;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen.
// Instance A uses the default 640x480 timing and covers line-level
// behaviour. Instance B uses a tiny 25x15 raster (375 cycles per frame), so
// several whole frames fit in a short run.
// Each cycle, a reference model predicts the next outputs of both instances
// and pushes them to a queue. After the clock edge the prediction is popped
// and compared with the DUT outputs.
module tb_vga_sync_gen;

  localparam int W = 25;  // {x[9:0], y[9:0], hs, vs, blank, sync, frame_start}

  // Instance B timing.
  localparam int BHV = 16, BHF = 2, BHS = 3, BHB = 4;
  localparam int BVV = 8,  BVF = 2, BVS = 2, BVB = 3;
  localparam int BHT = BHV + BHF + BHS + BHB;  // 25
  localparam int BVT = BVV + BVF + BVS + BVB;  // 15

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a = 1'b1;
  logic       reset_b = 1'b1;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic       a_hs, a_vs, a_blank, a_sync, a_fs;
  logic       b_hs, b_vs, b_blank, b_sync, b_fs;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  vga_sync_gen dut_a (
    .vga_clk(clk), .Reset(reset_a), .DrawX(a_x), .DrawY(a_y),
    .hs(a_hs), .vs(a_vs), .blank(a_blank), .sync(a_sync),
    .frame_start(a_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_count(a_cnt)
`endif
  );

  vga_sync_gen #(
    .H_VISIBLE(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_VISIBLE(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
  ) dut_b (
    .vga_clk(clk), .Reset(reset_b), .DrawX(b_x), .DrawY(b_y),
    .hs(b_hs), .vs(b_vs), .blank(b_blank), .sync(b_sync),
    .frame_start(b_fs)
`ifdef VGA_SYNC_FRAME_CNT_EN
    , .frame_count(b_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0]  exp_cnt_q[$];
  logic [15:0]  m_cnt_b = 16'd0;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  // Model positions: the coordinates the DUT currently shows.
  int m_ax = 0, m_ay = 0, m_bx = 0, m_by = 0;

  // Advances one position, or returns to (0,0) on reset. fs is set only on a
  // real frame wrap.
  task automatic model_step(inout int x, inout int y, input int ht, input int vt,
                            input logic rst, output logic fs);
    fs = 1'b0;
    if (rst) begin
      x = 0; y = 0;
    end else if (x == ht - 1) begin
      x = 0;
      if (y == vt - 1) begin y = 0; fs = 1'b1; end
      else y = y + 1;
    end else begin
      x = x + 1;
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input int x, input int y, input logic fs,
      input int hv, input int hf, input int hsw, input int vv, input int vf, input int vsw);
    logic hs_e, vs_e, bl_e;
    hs_e = !((x >= hv + hf) && (x < hv + hf + hsw));
    vs_e = !((y >= vv + vf) && (y < vv + vf + vsw));
    bl_e = (x < hv) && (y < vv);
    return {x[9:0], y[9:0], hs_e, vs_e, bl_e, 1'b0, fs};
  endfunction

  task automatic compare_fields(input string who, input logic [W-1:0] obs, input logic [W-1:0] exp);
    check_eq({who, ".DrawX"},       32'(obs[24:15]), 32'(exp[24:15]));
    check_eq({who, ".DrawY"},       32'(obs[14:5]),  32'(exp[14:5]));
    check_eq({who, ".hs"},          32'(obs[4]),     32'(exp[4]));
    check_eq({who, ".vs"},          32'(obs[3]),     32'(exp[3]));
    check_eq({who, ".blank"},       32'(obs[2]),     32'(exp[2]));
    check_eq({who, ".sync"},        32'(obs[1]),     32'(exp[1]));
    check_eq({who, ".frame_start"}, 32'(obs[0]),     32'(exp[0]));
  endtask

  // ---------------- observation counters ----------------
  bit a_seen_y1     = 0;
  int a_hs_first    = -1, a_hs_last = -1, a_hs_cnt = 0, a_blank_fall = -1;
  int b_cyc         = 0, b_last_fs = -1, b_fs_cnt = 0;
  int b_vs_cnt      = 0, b_blank_bad = 0;
  bit b_first_frame = 1;

  // ---------------- driver ----------------
  // One clock: drive the resets, predict, wait for the edge, pop and compare.
  task automatic run_cycle(input logic rst_a, input logic rst_b);
    logic fs_a, fs_b;
    logic [W-1:0] exp_a, exp_b;
    @(negedge clk);
    reset_a = rst_a;
    reset_b = rst_b;
    model_step(m_ax, m_ay, 800, 525, rst_a, fs_a);
    model_step(m_bx, m_by, BHT, BVT, rst_b, fs_b);
    exp_q_a.push_back(pack_exp(m_ax, m_ay, fs_a, 640, 16, 96, 480, 10, 2));
    exp_q_b.push_back(pack_exp(m_bx, m_by, fs_b, BHV, BHF, BHS, BVV, BVF, BVS));
`ifdef VGA_SYNC_FRAME_CNT_EN
    if (rst_b) m_cnt_b = 16'd0;
    else if (fs_b) m_cnt_b = m_cnt_b + 16'd1;
    exp_cnt_q.push_back(m_cnt_b);
`endif
    @(posedge clk);
    #1;
    exp_a = exp_q_a.pop_front();
    exp_b = exp_q_b.pop_front();
    compare_fields("A", {a_x, a_y, a_hs, a_vs, a_blank, a_sync, a_fs}, exp_a);
    compare_fields("B", {b_x, b_y, b_hs, b_vs, b_blank, b_sync, b_fs}, exp_b);
`ifdef VGA_SYNC_FRAME_CNT_EN
    check_eq("B.frame_count", 32'(b_cnt), 32'(exp_cnt_q.pop_front()));
    check_eq("A.frame_count", 32'(a_cnt), 32'd0);
`endif
    // Line-0 statistics on instance A.
    if (a_y == 10'd1) a_seen_y1 = 1;
    if (!a_seen_y1 && a_y == 10'd0) begin
      if (!a_hs) begin
        if (a_hs_first < 0) a_hs_first = int'(a_x);
        a_hs_last = int'(a_x);
        a_hs_cnt++;
      end
      if (!a_blank && a_blank_fall < 0) a_blank_fall = int'(a_x);
    end
    // Frame statistics on instance B.
    b_cyc++;
    if (int'(b_y) >= BVV && b_blank) b_blank_bad++;
    if (b_fs) begin
      if (b_last_fs >= 0) check_eq("B.fs_period", 32'(b_cyc - b_last_fs), 32'(BHT * BVT));
      b_last_fs = b_cyc;
      b_fs_cnt++;
      b_first_frame = 0;
    end
    if (b_first_frame && !b_vs) b_vs_cnt++;
  endtask

  // ---------------- sequence ----------------
  initial begin
    int guard;
    // Reset held for 3 cycles: all outputs at reset values each cycle.
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);

    // Free-run: covers A's first line and more than three frames of B.
    for (int i = 0; i < 3 * BHT * BVT + 60; i++) run_cycle(1'b0, 1'b0);

    check_eq("A.hs_first_x", 32'(a_hs_first), 32'd656);
    check_eq("A.hs_last_x",  32'(a_hs_last),  32'd751);
    check_eq("A.hs_width",   32'(a_hs_cnt),   32'd96);
    check_eq("A.blank_fall", 32'(a_blank_fall), 32'd640);
    check_eq("A.saw_line1",  32'(a_seen_y1),  32'd1);
    check_eq("B.vs_low_cycles", 32'(b_vs_cnt), 32'(BVS * BHT));
    check_eq("B.fs_count",   32'(b_fs_cnt),   32'd3);

    // Mid-frame reset on A at (300,2); (300,200) is out of reach in a short
    // run at default timing.
    guard = 0;
    while (!(m_ax == 300 && m_ay == 2) && guard < 4000) begin
      run_cycle(1'b0, 1'b0); guard++;
    end
    check_eq("A.reach_300_2", 32'(guard < 4000), 32'd1);
    run_cycle(1'b1, 1'b0);  // expected (0,0) with reset values
    run_cycle(1'b0, 1'b0);  // expected (1,0)
    check_eq("A.after_reset_x", 32'(a_x), 32'd1);

    // Mid-frame reset on B at (10,5).
    guard = 0;
    while (!(m_bx == 10 && m_by == 5) && guard < 1000) begin
      run_cycle(1'b0, 1'b0); guard++;
    end
    check_eq("B.reach_10_5", 32'(guard < 1000), 32'd1);
    run_cycle(1'b0, 1'b1);
    b_last_fs = -1;  // the interrupted frame is no full period
    run_cycle(1'b0, 1'b0);
    check_eq("B.after_reset_x", 32'(b_x), 32'd1);
    for (int i = 0; i < 2 * BHT * BVT + 10; i++) run_cycle(1'b0, 1'b0);

`ifdef VGA_SYNC_FRAME_CNT_EN
    // Preload the counter near its top, then cross the next frame boundary.
    @(negedge clk);
    force dut_b.r_frame_count = 16'hFFFF;
    #1;
    release dut_b.r_frame_count;
    m_cnt_b = 16'hFFFF;
    for (int i = 0; i < BHT * BVT + 5; i++) run_cycle(1'b0, 1'b0);
    check_eq("B.frame_count_wrap", 32'(b_cnt), 32'd0);
`endif

    check_eq("B.blank_in_vblank", 32'(b_blank_bad), 32'd0);
    check_eq("B.queue_drained", 32'(exp_q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
